// File: rtl/user_entry.sv
// Operator front end: synchronised, debounced inc/dec/start buttons editing a
// bounded operand, with optional auto-repeat and a valid/ready submit port.
module user_entry #(
  parameter int W             = 8,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 2**W - 1,
  parameter int WRAP          = 0,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4,
  parameter int LED_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             start_i,
  output logic [W-1:0]     value_o,
  output logic [W-1:0]     data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LED_W-1:0] leds_no
);

  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [RP_W-1:0] DLY_LAST = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [W-1:0]    MIN_V    = W'(MIN_VAL);
  localparam logic [W-1:0]    MAX_V    = W'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } rep_state_t;

  logic [2:0] raw_btn;
  logic [2:0] deb;
  logic [2:0] press;
  logic [1:0] step;

  assign raw_btn = {start_i, dec_i, inc_i};

  // Per-button: 2-flop synchroniser, stable-count debouncer, rising-edge press pulse
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            deb_reg;
      logic            deb_d_reg;
      logic [DB_W-1:0] db_cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          deb_reg    <= 1'b0;
          deb_d_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw_btn[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          if (sync2_reg != deb_reg) begin
            if (db_cnt_reg == DB_LAST) begin
              deb_reg    <= sync2_reg;
              db_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
        end
      end

      assign deb[gi]   = deb_reg;
      assign press[gi] = deb_reg & ~deb_d_reg;
    end

    // Auto-repeat FSMs for inc (0) and dec (1); step is a single-cycle strobe
    for (gi = 0; gi < 2; gi++) begin : g_rep
      rep_state_t      state_reg;
      logic [RP_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              cnt_reg <= '0;
              if (press[gi] && (REPEAT_DELAY > 0)) state_reg <= ST_HOLD;
            end
            ST_HOLD: begin
              if (!deb[gi]) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
              end else if (cnt_reg == DLY_LAST) begin
                state_reg <= ST_REPEAT;
                cnt_reg   <= '0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (!deb[gi]) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
              end else if (cnt_reg == PER_LAST) begin
                cnt_reg <= '0;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
            default: begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
            end
          endcase
        end
      end

      assign step[gi] = (state_reg == ST_IDLE)   ? press[gi] :
                        (state_reg == ST_HOLD)   ? (deb[gi] && (cnt_reg == DLY_LAST)) :
                        (state_reg == ST_REPEAT) ? (deb[gi] && (cnt_reg == PER_LAST)) :
                        1'b0;
    end
  endgenerate

  logic [W-1:0]     value_reg;
  logic [W-1:0]     value_next;
  logic [W-1:0]     data_reg;
  logic             valid_reg;
  logic [LED_W-1:0] leds_reg;

  always_comb begin
    value_next = value_reg;
    if (step == 2'b01) begin
      if (value_reg == MAX_V) value_next = (WRAP != 0) ? MIN_V : MAX_V;
      else                    value_next = value_reg + 1'b1;
    end else if (step == 2'b10) begin
      if (value_reg == MIN_V) value_next = (WRAP != 0) ? MAX_V : MIN_V;
      else                    value_next = value_reg - 1'b1;
    end
  end

  // A start press only loads when nothing is pending; it is never queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= MIN_V;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      leds_reg  <= '1;
    end else begin
      value_reg <= value_next;
      if (valid_reg) begin
        if (ready_i) valid_reg <= 1'b0;
      end else if (press[2]) begin
        data_reg  <= value_reg;
        leds_reg  <= ~value_reg[LED_W-1:0];
        valid_reg <= 1'b1;
      end
    end
  end

  assign value_o = value_reg;
  assign data_o  = data_reg;
  assign valid_o = valid_reg;
  assign leds_no = leds_reg;

endmodule

// File: tb/tb_user_entry.sv
// Directed bench for user_entry: four instances cover defaults, auto-repeat,
// and saturating / wrapping bounds.
module tb_user_entry;

  logic       clk;
  logic       rst;
  logic [3:0] inc;
  logic [3:0] dec;
  logic [3:0] start;
  logic [3:0] ready;
  logic [7:0] value_s [4];
  logic [7:0] data_s  [4];
  logic [3:0] valid_s;
  logic [3:0] leds_s  [4];

  int checks;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults, no auto-repeat
  user_entry #(.REPEAT_DELAY(0)) u_a (
    .clk(clk), .rst(rst), .inc_i(inc[0]), .dec_i(dec[0]), .start_i(start[0]),
    .value_o(value_s[0]), .data_o(data_s[0]), .valid_o(valid_s[0]),
    .ready_i(ready[0]), .leds_no(leds_s[0]));

  // 1: defaults with auto-repeat (delay 8, period 4)
  user_entry u_b (
    .clk(clk), .rst(rst), .inc_i(inc[1]), .dec_i(dec[1]), .start_i(start[1]),
    .value_o(value_s[1]), .data_o(data_s[1]), .valid_o(valid_s[1]),
    .ready_i(ready[1]), .leds_no(leds_s[1]));

  // 2: bounds 2..9, saturate
  user_entry #(.MIN_VAL(2), .MAX_VAL(9), .WRAP(0), .REPEAT_DELAY(0)) u_c (
    .clk(clk), .rst(rst), .inc_i(inc[2]), .dec_i(dec[2]), .start_i(start[2]),
    .value_o(value_s[2]), .data_o(data_s[2]), .valid_o(valid_s[2]),
    .ready_i(ready[2]), .leds_no(leds_s[2]));

  // 3: bounds 2..9, wrap
  user_entry #(.MIN_VAL(2), .MAX_VAL(9), .WRAP(1), .REPEAT_DELAY(0)) u_d (
    .clk(clk), .rst(rst), .inc_i(inc[3]), .dec_i(dec[3]), .start_i(start[3]),
    .value_o(value_s[3]), .data_o(data_s[3]), .valid_o(valid_s[3]),
    .ready_i(ready[3]), .leds_no(leds_s[3]));

  typedef struct {
    int         idx;
    bit         do_inc;
    bit         do_dec;
    int         n;
    int         hold;
    logic [7:0] exp_val;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // n clean presses; 12 release cycles lets the debounced level fall between presses
  task automatic press(input int idx, input bit i, input bit d, input int n, input int hold);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      inc[idx] = i;
      dec[idx] = d;
      repeat (hold) @(negedge clk);
      inc[idx] = 1'b0;
      dec[idx] = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic press_start(input int idx);
    @(negedge clk);
    start[idx] = 1'b1;
    repeat (6) @(negedge clk);
    start[idx] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    inc    = '0;
    dec    = '0;
    start  = '0;
    ready  = '0;

    //          idx inc dec  n hold exp
    vecs[0]  = '{0, 1'b1, 1'b0, 2, 20, 8'd3};
    vecs[1]  = '{0, 1'b0, 1'b1, 1, 20, 8'd2};
    vecs[2]  = '{0, 1'b1, 1'b1, 1, 20, 8'd2};
    vecs[3]  = '{2, 1'b0, 1'b1, 1, 10, 8'd2};
    vecs[4]  = '{2, 1'b1, 1'b0, 7, 10, 8'd9};
    vecs[5]  = '{2, 1'b1, 1'b0, 1, 10, 8'd9};
    vecs[6]  = '{2, 1'b0, 1'b1, 1, 10, 8'd8};
    vecs[7]  = '{2, 1'b1, 1'b1, 1, 10, 8'd8};
    vecs[8]  = '{3, 1'b0, 1'b1, 1, 10, 8'd9};
    vecs[9]  = '{3, 1'b1, 1'b0, 1, 10, 8'd2};
    vecs[10] = '{3, 1'b1, 1'b0, 3, 10, 8'd5};
    vecs[11] = '{3, 1'b1, 1'b1, 1, 10, 8'd5};

    repeat (2) @(negedge clk);
    check("rst_value",   value_s[0], 0);
    check("rst_valid",   valid_s[0], 0);
    check("rst_data",    data_s[0],  0);
    check("rst_leds",    leds_s[0],  4'hf);
    check("rst_min_val", value_s[2], 2);
    $display("reset: value=%0d valid=%0d data=%0d leds=%b", value_s[0], valid_s[0], data_s[0], leds_s[0]);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Press-to-step latency: step lands on the 7th edge after the raw edge
    @(negedge clk);
    inc[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("latency_before", value_s[0], 0);
    @(negedge clk);
    check("latency_after", value_s[0], 1);
    repeat (13) @(negedge clk);
    inc[0] = 1'b0;
    repeat (20) @(negedge clk);
    $display("latency press: value=%0d", value_s[0]);

    for (int v = 0; v < 12; v++) begin
      press(vecs[v].idx, vecs[v].do_inc, vecs[v].do_dec, vecs[v].n, vecs[v].hold);
      check($sformatf("vec%0d_value", v), value_s[vecs[v].idx], vecs[v].exp_val);
      $display("vec %0d: inst=%0d inc=%0d dec=%0d n=%0d value=%0d exp=%0d",
               v, vecs[v].idx, vecs[v].do_inc, vecs[v].do_dec, vecs[v].n,
               value_s[vecs[v].idx], vecs[v].exp_val);
    end

    // Bounce: 3 high, 2 low, 3 high never reaches 4 stable cycles
    @(negedge clk);
    inc[0] = 1'b1;
    repeat (3) @(negedge clk);
    inc[0] = 1'b0;
    repeat (2) @(negedge clk);
    inc[0] = 1'b1;
    repeat (3) @(negedge clk);
    inc[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("bounce_inc", value_s[0], 2);
    dec[0] = 1'b1;
    @(negedge clk);
    dec[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_dec", value_s[0], 2);
    $display("bounce/glitch: value=%0d", value_s[0]);

    // Auto-repeat: debounced level high 40 cycles -> steps at t=0,8,12,...,36
    @(negedge clk);
    inc[1] = 1'b1;
    repeat (40) @(negedge clk);
    inc[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("repeat_count", value_s[1], 9);
    repeat (20) @(negedge clk);
    check("repeat_after_release", value_s[1], 9);
    $display("auto-repeat: value=%0d", value_s[1]);

    press(1, 1'b1, 1'b0, 4, 6);
    check("pre_handshake_value", value_s[1], 13);

    // First start, ready low: valid rises with the same latency as a step
    @(negedge clk);
    start[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("start_valid_before", valid_s[1], 0);
    @(negedge clk);
    check("start_valid", valid_s[1], 1);
    check("start_data",  data_s[1], 13);
    check("start_leds",  leds_s[1], 4'b0010);
    start[1] = 1'b0;
    repeat (12) @(negedge clk);
    $display("start 1: valid=%0d data=%0d leds=%b", valid_s[1], data_s[1], leds_s[1]);

    press(1, 1'b1, 1'b0, 1, 6);
    check("edit_while_valid", value_s[1], 14);
    press_start(1);
    check("second_start_data",  data_s[1], 13);
    check("second_start_valid", valid_s[1], 1);
    $display("start 2 ignored: valid=%0d data=%0d value=%0d", valid_s[1], data_s[1], value_s[1]);

    ready[1] = 1'b1;
    @(negedge clk);
    ready[1] = 1'b0;
    check("transfer_valid", valid_s[1], 0);
    check("transfer_data",  data_s[1], 13);
    check("transfer_leds",  leds_s[1], 4'b0010);
    $display("transfer: valid=%0d data=%0d", valid_s[1], data_s[1]);

    press_start(1);
    check("start3_valid", valid_s[1], 1);
    check("start3_data",  data_s[1], 14);
    check("start3_leds",  leds_s[1], 4'b0001);
    $display("start 3: valid=%0d data=%0d leds=%b", valid_s[1], data_s[1], leds_s[1]);

    // Reset while repeating with a pending handshake; reset must act without a clock edge
    @(negedge clk);
    inc[1] = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_value", value_s[1], 0);
    check("midrst_valid", valid_s[1], 0);
    check("midrst_data",  data_s[1], 0);
    check("midrst_leds",  leds_s[1], 4'hf);
    $display("mid-op reset: value=%0d valid=%0d data=%0d leds=%b", value_s[1], valid_s[1], data_s[1], leds_s[1]);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_before", value_s[1], 0);
    @(negedge clk);
    check("post_rst_step", value_s[1], 1);
    inc[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_single", value_s[1], 1);
    $display("post-reset hold: value=%0d", value_s[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
